// File: rtl/dmem_access_ctl.sv
// dmem_access_ctl: load/store sequencer for a single-port synchronous data RAM.
// Sub-word stores are read-modify-write; sub-word loads are extracted and extended.
module dmem_access_ctl #(
  parameter int n  = 32,
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic [n-1:0]  req_wdata_i,
  input  logic [3:0]    req_opcode_i,
  output logic          rsp_valid_o,
  output logic [n-1:0]  rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [n-1:0]  mem_wdata_o,
  input  logic [n-1:0]  mem_rdata_i
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;
  state_t r_state, w_next;
  logic [3:0]   r_op;
  logic [1:0]   r_off;
  logic [15:0]  r_wdata;
  logic         r_ready, r_rsp_valid, r_err, r_mem_en, r_mem_we;
  logic [n-1:0] r_rdata, r_mem_wdata;
  logic [AW-1:0] r_mem_addr;
  logic         w_hs, w_in_err, w_is_load;
  logic [15:0]  w_sel;
  logic [n-1:0] w_mask, w_ins, w_merged, w_ld;
  always_comb begin
    w_hs      = req_valid_i & r_ready;
    w_in_err  = (req_opcode_i == 4'd1 || req_opcode_i == 4'd5 || req_opcode_i == 4'd8) ? req_addr_i[0] :
                (req_opcode_i == 4'd2 || req_opcode_i == 4'd6) ? |req_addr_i[1:0] :
                (req_opcode_i == 4'd0 || req_opcode_i == 4'd4 || req_opcode_i == 4'd7) ? 1'b0 : 1'b1;
    w_is_load = r_op[2] | r_op[3];
    w_sel     = 16'(mem_rdata_i >> {r_off, 3'b000});
    w_mask    = (r_op == 4'd0) ? 32'hFF << {r_off, 3'b000} : 32'hFFFF << {r_off[1], 4'b0000};
    w_ins     = (r_op == 4'd0) ? {4{r_wdata[7:0]}} : {2{r_wdata}};
    w_merged  = (mem_rdata_i & ~w_mask) | (w_ins & w_mask);
    w_ld      = (r_op == 4'd4) ? {{24{w_sel[7]}}, w_sel[7:0]} :
                (r_op == 4'd5) ? {{16{w_sel[15]}}, w_sel} :
                (r_op == 4'd7) ? {24'b0, w_sel[7:0]} :
                (r_op == 4'd8) ? {16'b0, w_sel} : mem_rdata_i;
    w_next    = r_state;
    case (r_state)
      S_IDLE:  w_next = !w_hs ? S_IDLE : w_in_err ? S_DONE : (req_opcode_i == 4'd2) ? S_WR : S_RD;
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = w_is_load ? S_DONE : S_WR;
      S_WR:    w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next;
      r_ready     <= w_next == S_IDLE;
      r_rsp_valid <= w_next == S_DONE;
      r_err       <= w_hs & w_in_err;
      r_rdata     <= (r_state == S_CAP && w_is_load) ? w_ld : '0;
      r_mem_en    <= w_next == S_RD || w_next == S_WR;
      r_mem_we    <= w_next == S_WR;
      if (w_hs) begin
        r_op       <= req_opcode_i;
        r_off      <= req_addr_i[1:0];
        r_wdata    <= req_wdata_i[15:0];
        r_mem_addr <= {req_addr_i[AW-1:2], 2'b00};
      end
      if (w_hs && req_opcode_i == 4'd2)
        r_mem_wdata <= req_wdata_i;
      else if (r_state == S_CAP && !w_is_load)
        r_mem_wdata <= w_merged;
    end
  end
  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign mem_en_o    = r_mem_en;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
endmodule
